cr_prefix_fe_ctlr: RTL

- Feature-extraction controller; the transmit side of the fe_char interface consumed by the prefix feature counter group.
- Accepts a valid/ready 64-bit byte stream of data blocks of up to 4 KB.
- Drives fe_char_in, fe_char_vbytes, fe_sel_1k and fe_ctlr_eodb toward the counter group.
- After end of block, waits for the counter pipeline to drain, then presents fe_ctr_vld and holds it until fe_ctr_ack.

---
 rtl/cr_prefix_fe_ctlr_pkg.sv | 22 ++
 rtl/cr_prefix_fe_ctlr.sv | 128 ++++++++++++
 2 files changed

// File: rtl/cr_prefix_fe_ctlr_pkg.sv
// Shared types and constants for the prefix feature-extraction controller.
package cr_prefix_fe_ctlr_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    DONE   = 2'd2
  } fe_ctlr_st_e;

  localparam int FE_BEATS_PER_1K = 128;
  localparam int FE_MAX_BEATS    = 512;

  // Byte counts above 8 are clamped so a bad count can never widen the mask.
  function automatic logic [7:0] fe_bytes_to_mask(input logic [3:0] in_bytes);
    logic [3:0] w_n;
    logic [8:0] w_m;
    w_n = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    w_m = (9'd1 << w_n) - 9'd1;
    return w_m[7:0];
  endfunction

endpackage

// File: rtl/cr_prefix_fe_ctlr.sv
// Transmit side of the fe_char interface: registers accepted beats toward the
// prefix counter group, then waits for the counter pipeline and a consumer ack.
//
//   state  | meaning
//   ACTIVE | accepting beats, in_rdy=1
//   DRAIN  | eob seen, waiting DRAIN_CYCLES for the counter pipeline
//   DONE   | fe_ctr_vld=1, waiting for fe_ctr_ack
module cr_prefix_fe_ctlr
  import cr_prefix_fe_ctlr_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [63:0] in_data,
  input  logic        in_eob,
  input  logic [3:0]  in_bytes,
  output logic [63:0] fe_char_in,
  output logic [7:0]  fe_char_vbytes,
  output logic [1:0]  fe_sel_1k,
  output logic        fe_ctlr_eodb,
  output logic        fe_ctr_vld,
  input  logic        fe_ctr_ack,
  output logic        fe_ovfl
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  fe_ctlr_st_e r_state;
  logic [9:0]  r_beat_cnt;
  logic [3:0]  r_drain_cnt;
  logic        r_in_rdy;
  logic [63:0] r_char;
  logic [7:0]  r_vbytes;
  logic [1:0]  r_sel;
  logic        r_eodb;
  logic        r_ctr_vld;
  logic        r_ovfl;

  logic        w_accept;
  logic        w_over;
  logic [7:0]  w_mask;
  logic [1:0]  w_sel;
  logic [63:0] w_data;

  assign w_accept = in_vld & r_in_rdy;
  assign w_over   = (r_beat_cnt >= 10'(FE_MAX_BEATS));
  assign w_mask   = w_over ? 8'h00 : (in_eob ? fe_bytes_to_mask(in_bytes) : 8'hFF);
  assign w_sel    = w_over ? 2'd3 : 2'(r_beat_cnt / 10'(FE_BEATS_PER_1K));

  always_comb begin
    w_data = '0;
    for (int k = 0; k < 8; k++) begin
      if (w_mask[k]) w_data[8*k +: 8] = in_data[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ACTIVE;
      r_beat_cnt  <= '0;
      r_drain_cnt <= '0;
      r_in_rdy    <= 1'b1;
      r_char      <= '0;
      r_vbytes    <= '0;
      r_sel       <= '0;
      r_eodb      <= 1'b0;
      r_ctr_vld   <= 1'b0;
      r_ovfl      <= 1'b0;
    end else begin
      r_char   <= '0;
      r_vbytes <= '0;
      r_eodb   <= 1'b0;
      if (w_accept) begin
        r_char   <= w_data;
        r_vbytes <= w_mask;
        r_eodb   <= in_eob;
        r_sel    <= w_sel;
        // beat_cnt==0 marks the first beat of a block, which drops the old sticky flag
        r_ovfl   <= w_over | (r_ovfl & (r_beat_cnt != 10'd0));
        if (in_eob)
          r_beat_cnt <= '0;
        else if (r_beat_cnt != 10'h3FF)
          r_beat_cnt <= r_beat_cnt + 10'd1;
      end

      case (r_state)
        ACTIVE: begin
          if (w_accept && in_eob) begin
            r_state     <= DRAIN;
            r_in_rdy    <= 1'b0;
            r_drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (r_drain_cnt == 4'd0) begin
            r_state   <= DONE;
            r_ctr_vld <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 4'd1;
          end
        end
        DONE: begin
          if (fe_ctr_ack) begin
            r_state   <= ACTIVE;
            r_in_rdy  <= 1'b1;
            r_ctr_vld <= 1'b0;
          end
        end
        default: begin
          r_state  <= ACTIVE;
          r_in_rdy <= 1'b1;
        end
      endcase
    end
  end

  assign in_rdy         = r_in_rdy;
  assign fe_char_in     = r_char;
  assign fe_char_vbytes = r_vbytes;
  assign fe_sel_1k      = r_sel;
  assign fe_ctlr_eodb   = r_eodb;
  assign fe_ctr_vld     = r_ctr_vld;
  assign fe_ovfl        = r_ovfl;

endmodule
